// File: rtl/vga_sync_decoder_if.sv
// Sampled VGA input pins and recovered timing outputs of the sync decoder.
// VGA_DEC_CHECKSUM_EN adds the per-frame colour checksum signals.
interface vga_sync_decoder_if;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_R2;
  logic       VGA_G2;
  logic       VGA_B2;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic [2:0] pix_rgb;
  logic       pixel_valid;
  logic       locked;
  logic       frame_start;
  logic       err_h;
  logic       err_v;
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        frame_sum_valid;

  modport master (
    output VGA_HS, VGA_VS, VGA_R2, VGA_G2, VGA_B2,
    input  h_pos, v_pos, pix_rgb, pixel_valid, locked, frame_start, err_h, err_v,
    input  frame_sum, frame_sum_valid
  );
  modport slave (
    input  VGA_HS, VGA_VS, VGA_R2, VGA_G2, VGA_B2,
    output h_pos, v_pos, pix_rgb, pixel_valid, locked, frame_start, err_h, err_v,
    output frame_sum, frame_sum_valid
  );
`else
  modport master (
    output VGA_HS, VGA_VS, VGA_R2, VGA_G2, VGA_B2,
    input  h_pos, v_pos, pix_rgb, pixel_valid, locked, frame_start, err_h, err_v
  );
  modport slave (
    input  VGA_HS, VGA_VS, VGA_R2, VGA_G2, VGA_B2,
    output h_pos, v_pos, pix_rgb, pixel_valid, locked, frame_start, err_h, err_v
  );
`endif
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel position, lock and sync errors, 2-cycle latency, no backpressure.
// Optional VGA_DEC_CHECKSUM_EN adds a per-frame sum of pix_rgb over the active area.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  vga_sync_decoder_if.slave vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FRONT + H_PULSE);
  localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FRONT + V_PULSE);
  localparam logic [9:0] H_ACT  = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT  = 10'(V_DISPLAY);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hs_a_q, hs_h_q, vs_a_q, vs_h_q;
  logic [2:0] rgb_a_q, pix_q;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       lk_q, lk_d, pv_q, pv_d, fs_q, fs_d, eh_q, eh_d, ev_q, ev_d;

  logic       hs_rise, hs_fall, vs_rise, vs_fall;
  logic       eh_raw, ev_raw, any_err;
  logic [9:0] h_pred, v_pred;

  always_comb begin
    hs_rise = hs_a_q & ~hs_h_q;
    hs_fall = ~hs_a_q & hs_h_q;
    vs_rise = vs_a_q & ~vs_h_q;
    vs_fall = ~vs_a_q & vs_h_q;

    h_pred = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_pred = v_q;
    if (h_q == H_LAST) begin
      v_pred = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    eh_raw = (hs_rise && (h_pred != H_SS)) || (hs_fall && (h_pred != H_SE));
    ev_raw = (vs_rise && ((h_pred != 10'd0) || (v_pred != V_SS))) ||
             (vs_fall && ((h_pred != 10'd0) || (v_pred != V_SE)));

    // Sync edges realign the free-running counters; VS wins over HS for h.
    h_d = h_pred;
    v_d = v_pred;
    if (hs_rise) begin
      h_d = H_SS;
    end
    if (vs_rise) begin
      h_d = 10'd0;
      v_d = V_SS;
    end

    eh_d    = eh_raw && (state_q != SEARCH);
    ev_d    = ev_raw && (state_q != SEARCH);
    any_err = eh_d || ev_d;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = SYNC;
          cnt_d   = 4'd0;
        end
      end
      SYNC: begin
        if (any_err) begin
          state_d = SEARCH;
          cnt_d   = 4'd0;
        end else if (vs_rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LOCK_N) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_d = SEARCH;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = SEARCH;
        cnt_d   = 4'd0;
      end
    endcase

    lk_d = (state_d == LOCKED);
    pv_d = lk_d && (h_d < H_ACT) && (v_d < V_ACT);
    fs_d = lk_d && (h_d == 10'd0) && (v_d == 10'd0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEARCH;
      cnt_q   <= 4'd0;
      hs_a_q  <= 1'b0;
      hs_h_q  <= 1'b0;
      vs_a_q  <= 1'b0;
      vs_h_q  <= 1'b0;
      rgb_a_q <= 3'd0;
      pix_q   <= 3'd0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      lk_q    <= 1'b0;
      pv_q    <= 1'b0;
      fs_q    <= 1'b0;
      eh_q    <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_a_q  <= vga.VGA_HS;
      hs_h_q  <= hs_a_q;
      vs_a_q  <= vga.VGA_VS;
      vs_h_q  <= vs_a_q;
      rgb_a_q <= {vga.VGA_R2, vga.VGA_G2, vga.VGA_B2};
      pix_q   <= rgb_a_q;
      h_q     <= h_d;
      v_q     <= v_d;
      lk_q    <= lk_d;
      pv_q    <= pv_d;
      fs_q    <= fs_d;
      eh_q    <= eh_d;
      ev_q    <= ev_d;
    end
  end

  assign vga.h_pos       = h_q;
  assign vga.v_pos       = v_q;
  assign vga.pix_rgb     = pix_q;
  assign vga.pixel_valid = pv_q;
  assign vga.locked      = lk_q;
  assign vga.frame_start = fs_q;
  assign vga.err_h       = eh_q;
  assign vga.err_v       = ev_q;

`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] acc_q, sum_q;
  logic        sum_vld_q;

  // Accumulator only holds a partial frame while locked, so the first
  // frame_sum after lock covers a complete frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q     <= 16'd0;
      sum_q     <= 16'd0;
      sum_vld_q <= 1'b0;
    end else if (vs_rise && (state_q == LOCKED)) begin
      sum_q     <= acc_q;
      sum_vld_q <= 1'b1;
      acc_q     <= 16'd0;
    end else begin
      sum_vld_q <= 1'b0;
      if (state_q != LOCKED) begin
        acc_q <= 16'd0;
      end else if (pv_q) begin
        acc_q <= acc_q + {13'd0, pix_q};
      end
    end
  end

  assign vga.frame_sum       = sum_q;
  assign vga.frame_sum_valid = sum_vld_q;
`endif

endmodule
